serial_word_receiver: RTL and testbench
=======================================

// Module: serial_word_receiver
// PURPOSE
//  Serial-in/parallel-out receiver: the far end of our parallel-load rotate/shift registers.
//  Collects N bits from a 1-bit serial line and presents the assembled word in parallel.
//  Bits are strobed by ser_valid; the word is held until acknowledged.
//  Supports LSB-first (right-shift) and MSB-first (left-shift) framing.
//  Sits between a serial shifter output and LEDR/register consumers on the board.
// PARAMETERS
//  N      8   word width in bits (N >= 2)
//  CNT_W  3   bit-counter width; must satisfy 2**CNT_W >= N
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  start      in   1      frame sync pulse; begins a new word
//  dir        in   1      0 = LSB first, 1 = MSB first; sampled only when a frame starts
//  ser_in     in   1      serial data bit
//  ser_valid  in   1      ser_in is valid this cycle
//  word_ack   in   1      consumer has taken word_out
//  word_out   out  N      assembled word; held while word_valid = 1
//  word_valid out  1      level; high from capture until acknowledged
//  busy       out  1      high in SHIFT and LOAD
//  overrun    out  1      sticky: completed word dropped because word_valid was still high
//  frame_err  out  1      sticky: start seen while busy
// BEHAVIOUR
//  - Reset, checked at clk edge: state = IDLE, sreg = 0, count = 0, word_out = 0, word_valid = 0,
//    overrun = 0, frame_err = 0. Reset overrides every other input.
//  - IDLE: start -> SHIFT, latch dir into dir_q, clear sreg and count.
//    A ser_valid in the same cycle as start is not captured. ser_valid alone in IDLE is ignored.
//  - SHIFT: each ser_valid cycle shifts ser_in into sreg and increments count.
//    dir_q = 0: sreg <= {ser_in, sreg[N-1:1]}
//    dir_q = 1: sreg <= {sreg[N-2:0], ser_in}
//    When the Nth bit is accepted (count == N-1), go to LOAD and set count = 0.
//    Cycles without ser_valid leave sreg and count unchanged; there is no timeout.
//  - LOAD (1 cycle): if word_valid = 0, or word_ack = 1 this cycle: word_out <= sreg and word_valid <= 1.
//    Otherwise the new word is dropped, word_out keeps the old word, and overrun <= 1. Then go to IDLE.
//  - Latency: a bit presented with ser_valid in cycle c as the Nth bit gives word_valid high in cycle c+2.
//  - word_ack while word_valid = 1 and not in LOAD: word_valid <= 0 next cycle; word_out keeps its value.
//    word_ack while word_valid = 0 has no effect.
//  - start in SHIFT: abort and restart. Clear sreg and count, re-latch dir, set frame_err <= 1,
//    stay in SHIFT; no bit is captured that cycle.
//  - start in LOAD: ignored for framing (the load completes), and frame_err <= 1.
//  - overrun and frame_err are cleared only by reset.
//  - Back-to-back frames: start may be asserted in the first IDLE cycle after LOAD. Peak rate is N+2 cycles per word.
// STRUCTURE
//  - Shared package ser_rx_pkg (Verilog include) holds:
//    state encodings S_IDLE = 2'd0, S_SHIFT = 2'd1, S_LOAD = 2'd2;
//    constants DIR_LSB = 1'b0, DIR_MSB = 1'b1.
//  - One sub-module, ser_shift_core #(N): clk, clr, en, dir, din -> q[N-1:0].
//    It is the directional shift register only.
//  - The top level holds the FSM, bit counter, output holding register and sticky flags.
//  - Encoding 2'd3 is unreachable; decode it as IDLE.
// TESTING
//  1. Reset, then start, dir = 0, bits 1,0,1,1,0,0,1,0 with ser_valid each cycle
//     -> word_out = 8'h4D, word_valid high 2 cycles after the last bit, busy low afterwards.
//  2. Same bit sequence with dir = 1 -> word_out = 8'hB2.
//     Then word_ack -> word_valid = 0 next cycle and word_out still 8'hB2.
//  3. Gaps: ser_valid toggled 1,0,0,1,... over 8 accepted bits of 8'hFF
//     -> word_out = 8'hFF only after the 8th accepted bit; count does not advance on gap cycles.
//  4. Overrun: receive 8'h11 with no ack, then a full frame of 8'h22
//     -> word_out = 8'h11 and overrun = 1. Ack, then another frame of 8'h33 -> word_out = 8'h33.
//  5. Abort: start, 3 bits, start again, then 8 bits of 8'hA5 (dir = 0)
//     -> frame_err = 1 and word_out = 8'hA5, unaffected by the first 3 bits.
//  6. Reset mid-SHIFT after 5 bits -> all outputs 0 next cycle; a following full frame of 8'h3C decodes correctly.
//  7. Ack in the LOAD cycle with a word pending -> new word loaded, word_valid stays 1, overrun stays 0.

Source files
------------

// File: rtl/ser_rx_pkg.sv
// Shared types and constants for the serial word receiver.
package ser_rx_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_LOAD  = 2'd2
   } state_t;

   localparam logic DIR_LSB = 1'b0;
   localparam logic DIR_MSB = 1'b1;

endpackage

// File: rtl/ser_shift_core.sv
// Directional shift register: LSB-first shifts right, MSB-first shifts left.
module ser_shift_core
   import ser_rx_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   input  logic         dir,
   input  logic         din,
   output logic [N-1:0] q
);

   logic [N-1:0] r_q;

   // Clear has priority so a restart and a reset both drop partial bits.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_q <= '0;
      end else if (en) begin
         if (dir == DIR_MSB) r_q <= {r_q[N-2:0], din};
         else                r_q <= {din, r_q[N-1:1]};
      end
   end

   assign q = r_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-in/parallel-out receiver: frames N strobed bits into a held word with
// valid/ack handshake plus sticky overrun and framing-error flags.
module serial_word_receiver
   import ser_rx_pkg::*;
#(
   parameter int unsigned N     = 8,
   parameter int unsigned CNT_W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         dir,
   input  logic         ser_in,
   input  logic         ser_valid,
   input  logic         word_ack,
   output logic [N-1:0] word_out,
   output logic         word_valid,
   output logic         busy,
   output logic         overrun,
   output logic         frame_err
);

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_count, w_count_nxt;
   logic               r_dir, w_dir_nxt;
   logic [N-1:0]       r_word, w_word_nxt;
   logic               r_valid, w_valid_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_ovr, w_ovr_nxt;
   logic               r_ferr, w_ferr_nxt;
   logic               w_sh_clr, w_sh_en;
   logic [N-1:0]       w_sreg;

   ser_shift_core #(.N(N)) u_shift (
      .clk (clk),
      .clr (reset | w_sh_clr),
      .en  (w_sh_en),
      .dir (r_dir),
      .din (ser_in),
      .q   (w_sreg)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_dir   <= DIR_LSB;
         r_word  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_ovr   <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_dir   <= w_dir_nxt;
         r_word  <= w_word_nxt;
         r_valid <= w_valid_nxt;
         r_busy  <= w_busy_nxt;
         r_ovr   <= w_ovr_nxt;
         r_ferr  <= w_ferr_nxt;
      end
   end

   // Next-state and datapath control.
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_dir_nxt   = r_dir;
      w_word_nxt  = r_word;
      w_valid_nxt = r_valid;
      w_ovr_nxt   = r_ovr;
      w_ferr_nxt  = r_ferr;
      w_sh_clr    = 1'b0;
      w_sh_en     = 1'b0;

      if (word_ack && r_valid) w_valid_nxt = 1'b0;

      case (r_state)
         S_SHIFT: begin
            if (start) begin
               w_sh_clr    = 1'b1;
               w_count_nxt = '0;
               w_dir_nxt   = dir;
               w_ferr_nxt  = 1'b1;
            end else if (ser_valid) begin
               w_sh_en = 1'b1;
               if (r_count == CNT_W'(N - 1)) begin
                  w_count_nxt = '0;
                  w_state_nxt = S_LOAD;
               end else begin
                  w_count_nxt = r_count + CNT_W'(1);
               end
            end
         end
         S_LOAD: begin
            // An ack in this cycle frees the holding register for the new word.
            if (!r_valid || word_ack) begin
               w_word_nxt  = w_sreg;
               w_valid_nxt = 1'b1;
            end else begin
               w_ovr_nxt = 1'b1;
            end
            if (start) w_ferr_nxt = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            if (start) begin
               w_state_nxt = S_SHIFT;
               w_sh_clr    = 1'b1;
               w_count_nxt = '0;
               w_dir_nxt   = dir;
            end
         end
      endcase

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   assign word_out   = r_word;
   assign word_valid = r_valid;
   assign busy       = r_busy;
   assign overrun    = r_ovr;
   assign frame_err  = r_ferr;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench for serial_word_receiver: frame table, corner sequences, random vs model.
module tb_serial_word_receiver;

   localparam int unsigned N     = 8;
   localparam int unsigned CNT_W = 3;

   logic         clk = 1'b0;
   logic         reset, start, dir, ser_in, ser_valid, word_ack;
   logic [N-1:0] word_out;
   logic         word_valid, busy, overrun, frame_err;

   int checks = 0;
   int errors = 0;

   serial_word_receiver #(.N(N), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .dir        (dir),
      .ser_in     (ser_in),
      .ser_valid  (ser_valid),
      .word_ack   (word_ack),
      .word_out   (word_out),
      .word_valid (word_valid),
      .busy       (busy),
      .overrun    (overrun),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         d;
      logic [N-1:0] stream;      // bit i is the i-th transmitted bit
      bit           ack_before;
      logic [N-1:0] exp_word;
      logic         exp_ovr;
   } vec_t;

   vec_t tbl[6];

   // Behavioural reference: a frame is a list of bits; the word is placed by arithmetic.
   bit           m_active, m_pend, m_dir;
   bit           m_bits[$];
   logic [N-1:0] m_pend_word, m_word;
   bit           m_valid, m_ovr, m_ferr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_ack;
      word_ack = 1'b1;
      tick;
      word_ack = 1'b0;
   endtask

   task automatic send_frame(input logic d, input logic [N-1:0] stream, input bit ack_in_load);
      start = 1'b1;
      dir   = d;
      tick;
      start = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         ser_in    = stream[i];
         ser_valid = 1'b1;
         tick;
      end
      ser_valid = 1'b0;
      chk("busy_in_load", 32'(busy), 32'(1));
      word_ack = ack_in_load;
      tick;
      word_ack = 1'b0;
   endtask

   task automatic m_step;
      if (reset) begin
         m_active = 0; m_pend = 0; m_dir = 0; m_bits.delete();
         m_word = '0; m_valid = 0; m_ovr = 0; m_ferr = 0;
      end else if (m_pend) begin
         if (!m_valid || word_ack) begin
            m_word  = m_pend_word;
            m_valid = 1;
         end else begin
            m_ovr = 1;
         end
         if (start) m_ferr = 1;
         m_pend = 0;
      end else begin
         if (word_ack && m_valid) m_valid = 0;
         if (start) begin
            if (m_active) m_ferr = 1;
            m_active = 1;
            m_dir    = dir;
            m_bits.delete();
         end else if (m_active && ser_valid) begin
            m_bits.push_back(ser_in);
            if (m_bits.size() == int'(N)) begin
               m_pend      = 1;
               m_active    = 0;
               m_pend_word = '0;
               for (int i = 0; i < int'(N); i++)
                  m_pend_word[m_dir ? int'(N) - 1 - i : i] = m_bits[i];
            end
         end
      end
   endtask

   initial begin
      logic [N-1:0] prev;

      reset = 1'b1; start = 1'b0; dir = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; word_ack = 1'b0;
      tick; tick;
      reset = 1'b0;
      chk("reset_state", 32'({word_out, word_valid, busy, overrun, frame_err}), 32'(0));

      tbl[0] = '{1'b0, 8'h4D, 1'b0, 8'h4D, 1'b0};
      tbl[1] = '{1'b1, 8'h4D, 1'b1, 8'hB2, 1'b0};
      tbl[2] = '{1'b0, 8'h11, 1'b1, 8'h11, 1'b0};
      tbl[3] = '{1'b0, 8'h22, 1'b0, 8'h11, 1'b1};
      tbl[4] = '{1'b0, 8'h33, 1'b1, 8'h33, 1'b1};
      tbl[5] = '{1'b1, 8'h01, 1'b1, 8'h80, 1'b1};

      prev = '0;
      for (int i = 0; i < 6; i++) begin
         if (tbl[i].ack_before) begin
            do_ack;
            chk("ack_clears_valid", 32'(word_valid), 32'(0));
            chk("ack_keeps_word", 32'(word_out), 32'(prev));
         end
         send_frame(tbl[i].d, tbl[i].stream, 1'b0);
         chk("tbl_word", 32'(word_out), 32'(tbl[i].exp_word));
         chk("tbl_valid", 32'(word_valid), 32'(1));
         chk("tbl_busy_after", 32'(busy), 32'(0));
         chk("tbl_overrun", 32'(overrun), 32'(tbl[i].exp_ovr));
         prev = tbl[i].exp_word;
      end

      // Gaps between accepted bits must not advance the frame.
      do_ack;
      start = 1'b1; dir = 1'b0; tick; start = 1'b0;
      ser_in = 1'b1;
      for (int i = 0; i < 7; i++) begin
         ser_valid = 1'b1; tick;
         ser_valid = 1'b0; tick; tick;
      end
      chk("gap_no_early_word", 32'({word_valid, busy}), 32'(2'b01));
      ser_valid = 1'b1; tick;
      ser_valid = 1'b0; tick; tick;
      chk("gap_word", 32'({word_out, word_valid}), 32'({8'hFF, 1'b1}));

      // Abort and restart mid-frame.
      do_ack;
      chk("ferr_before_abort", 32'(frame_err), 32'(0));
      start = 1'b1; dir = 1'b0; tick; start = 1'b0;
      ser_in = 1'b1;
      for (int i = 0; i < 3; i++) begin ser_valid = 1'b1; tick; end
      ser_valid = 1'b0;
      send_frame(1'b0, 8'hA5, 1'b0);
      chk("abort_ferr", 32'(frame_err), 32'(1));
      chk("abort_word", 32'({word_out, word_valid}), 32'({8'hA5, 1'b1}));

      // Reset in the middle of a frame.
      start = 1'b1; dir = 1'b1; tick; start = 1'b0;
      for (int i = 0; i < 5; i++) begin ser_in = i[0]; ser_valid = 1'b1; tick; end
      ser_valid = 1'b0;
      reset = 1'b1; tick; reset = 1'b0;
      chk("midreset_outputs", 32'({word_out, word_valid, busy, overrun, frame_err}), 32'(0));
      send_frame(1'b0, 8'h3C, 1'b0);
      chk("post_reset_word", 32'({word_out, word_valid, overrun}), 32'({8'h3C, 2'b10}));

      // Ack in the LOAD cycle while a word is pending.
      send_frame(1'b1, 8'h0F, 1'b1);
      chk("ack_in_load", 32'({word_out, word_valid, overrun, frame_err}), 32'({8'hF0, 3'b100}));

      // Start during LOAD: load completes, frame error flagged, no new frame.
      do_ack;
      start = 1'b1; dir = 1'b0; tick; start = 1'b0;
      for (int i = 0; i < int'(N); i++) begin ser_in = i[0] ^ i[1]; ser_valid = 1'b1; tick; end
      ser_valid = 1'b0;
      start = 1'b1; tick; start = 1'b0; tick;
      chk("start_in_load", 32'({word_out, word_valid, busy, frame_err}), 32'({8'h66, 3'b101}));

      // Random traffic against the reference model.
      reset = 1'b1;
      m_step;
      tick;
      reset = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         reset     = ($urandom_range(299) == 0);
         start     = ($urandom_range(15) == 0);
         dir       = 1'($urandom_range(1));
         ser_in    = 1'($urandom_range(1));
         ser_valid = ($urandom_range(3) != 0);
         word_ack  = ($urandom_range(3) == 0);
         m_step;
         tick;
         chk("rand_cycle", 32'({word_out, word_valid, busy, overrun, frame_err}),
             32'({m_word, m_valid, m_active | m_pend, m_ovr, m_ferr}));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
